// File: rtl/dallanma_cozucu_if.sv
// Bus between the branch resolver and its neighbours: operation input,
// predictor update, fetch redirect, link result and the statistics counters.
interface dallanma_cozucu_if #(
  parameter int PS_BIT = 32
);
  // Operation from the issue stage
  logic              islem_gecerli_i;
  logic              islem_hazir_o;
  logic [3:0]        islem_tur_i;
  logic [PS_BIT-1:0] islem_ps_i;
  logic [PS_BIT-1:0] islem_rs1_i;
  logic [PS_BIT-1:0] islem_rs2_i;
  logic [PS_BIT-1:0] islem_imm_i;
  logic              islem_sikistirilmis_i;
  logic              islem_ongoru_atladi_i;
  logic [PS_BIT-1:0] islem_ongoru_adres_i;

  // Predictor update
  logic              yurut_guncelle_o;
  logic              yurut_atladi_o;
  logic              yurut_hatali_tahmin_o;
  logic [PS_BIT-1:0] yurut_ps_o;
  logic [PS_BIT-1:0] yurut_atlanan_adres_o;

  // Fetch redirect
  logic              ps_yonlendir_o;
  logic [PS_BIT-1:0] ps_yonlendir_adres_o;

  // Link result towards write-back
  logic              sonuc_gecerli_o;
  logic              sonuc_hazir_i;
  logic [PS_BIT-1:0] sonuc_deger_o;

  // Resolution statistics
  logic [31:0]       dogru_sayac_o;
  logic [31:0]       yanlis_sayac_o;

  // Resolver side
  modport slave (
    input  islem_gecerli_i, islem_tur_i, islem_ps_i, islem_rs1_i, islem_rs2_i,
           islem_imm_i, islem_sikistirilmis_i, islem_ongoru_atladi_i,
           islem_ongoru_adres_i, sonuc_hazir_i,
    output islem_hazir_o, yurut_guncelle_o, yurut_atladi_o, yurut_hatali_tahmin_o,
           yurut_ps_o, yurut_atlanan_adres_o, ps_yonlendir_o, ps_yonlendir_adres_o,
           sonuc_gecerli_o, sonuc_deger_o, dogru_sayac_o, yanlis_sayac_o
  );

  // Pipeline / driver side
  modport master (
    output islem_gecerli_i, islem_tur_i, islem_ps_i, islem_rs1_i, islem_rs2_i,
           islem_imm_i, islem_sikistirilmis_i, islem_ongoru_atladi_i,
           islem_ongoru_adres_i, sonuc_hazir_i,
    input  islem_hazir_o, yurut_guncelle_o, yurut_atladi_o, yurut_hatali_tahmin_o,
           yurut_ps_o, yurut_atlanan_adres_o, ps_yonlendir_o, ps_yonlendir_adres_o,
           sonuc_gecerli_o, sonuc_deger_o, dogru_sayac_o, yanlis_sayac_o
  );
endinterface

// File: rtl/dallanma_cozucu.sv
// Branch resolver: evaluates the branch condition and target of one operation
// per accept, reports the outcome to the predictor, redirects fetch on a
// misprediction (followed by one flush cycle) and returns the link value.
module dallanma_cozucu #(
  parameter int PS_BIT = 32
) (
  input logic               clk_i,
  input logic               rstn_i,
  dallanma_cozucu_if.slave  bus
);

  typedef enum logic [3:0] {
    TUR_BEQ  = 4'd0,
    TUR_BNE  = 4'd1,
    TUR_BLT  = 4'd2,
    TUR_BGE  = 4'd3,
    TUR_BLTU = 4'd4,
    TUR_BGEU = 4'd5,
    TUR_JAL  = 4'd6,
    TUR_JALR = 4'd7
  } tur_e;

  // NORMAL accepts operations; TEMIZLE is the single flush cycle after a redirect
  typedef enum logic {
    DURUM_NORMAL  = 1'b0,
    DURUM_TEMIZLE = 1'b1
  } durum_e;

  localparam logic [PS_BIT-1:0] ADIM_TAM   = PS_BIT'(4);
  localparam logic [PS_BIT-1:0] ADIM_YARIM = PS_BIT'(2);
  localparam logic [PS_BIT-1:0] BIT0_MASKE = ~PS_BIT'(1);
  localparam logic [31:0]       SAYAC_MAX  = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  durum_e            durum_q, durum_d;
  logic              yurut_guncelle_q, yurut_guncelle_d;
  logic              yurut_atladi_q, yurut_atladi_d;
  logic              yurut_hatali_q, yurut_hatali_d;
  logic [PS_BIT-1:0] yurut_ps_q, yurut_ps_d;
  logic [PS_BIT-1:0] yurut_adres_q, yurut_adres_d;
  logic              ps_yonlendir_q, ps_yonlendir_d;
  logic [PS_BIT-1:0] ps_yonlendir_adres_q, ps_yonlendir_adres_d;
  logic              sonuc_gecerli_q, sonuc_gecerli_d;
  logic [PS_BIT-1:0] sonuc_deger_q, sonuc_deger_d;
  logic [31:0]       dogru_sayac_q, dogru_sayac_d;
  logic [31:0]       yanlis_sayac_q, yanlis_sayac_d;

  // ---------------------------------------------------------------------------
  // Decode / evaluate
  // ---------------------------------------------------------------------------
  logic              islem_hazir;
  logic              kabul;
  logic              dal_mi;
  logic              esit, kucuk_isaretli, kucuk_isaretsiz;
  logic              atladi_c;
  logic              hatali_c;
  logic [PS_BIT-1:0] hedef_c;
  logic [PS_BIT-1:0] duz_c;
  logic [PS_BIT-1:0] bag_c;

  // Ready only in NORMAL with room in the result slot; forced low under reset
  // so that every output reads 0 while rstn_i is asserted.
  assign islem_hazir = rstn_i && (durum_q == DURUM_NORMAL) &&
                       (!sonuc_gecerli_q || bus.sonuc_hazir_i);
  assign kabul       = bus.islem_gecerli_i && islem_hazir;

  // Condition, target, fall-through and misprediction of the offered operation
  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    dal_mi          = ~bus.islem_tur_i[3];
    esit            = (bus.islem_rs1_i == bus.islem_rs2_i);
    kucuk_isaretli  = ($signed(bus.islem_rs1_i) < $signed(bus.islem_rs2_i));
    kucuk_isaretsiz = (bus.islem_rs1_i < bus.islem_rs2_i);

    atladi_c = 1'b0;
    case (bus.islem_tur_i)
      TUR_BEQ:  atladi_c = esit;
      TUR_BNE:  atladi_c = !esit;
      TUR_BLT:  atladi_c = kucuk_isaretli;
      TUR_BGE:  atladi_c = !kucuk_isaretli;
      TUR_BLTU: atladi_c = kucuk_isaretsiz;
      TUR_BGEU: atladi_c = !kucuk_isaretsiz;
      TUR_JAL:  atladi_c = 1'b1;
      TUR_JALR: atladi_c = 1'b1;
      default:  atladi_c = 1'b0;
    endcase

    if (bus.islem_tur_i == TUR_JALR) begin
      hedef_c = (bus.islem_rs1_i + bus.islem_imm_i) & BIT0_MASKE;
    end else begin
      hedef_c = bus.islem_ps_i + bus.islem_imm_i;
    end

    duz_c = bus.islem_ps_i + (bus.islem_sikistirilmis_i ? ADIM_YARIM : ADIM_TAM);

    if ((bus.islem_tur_i == TUR_JAL) || (bus.islem_tur_i == TUR_JALR)) begin
      bag_c = duz_c;
    end else begin
      bag_c = '0;
    end

    // Wrong direction, or right direction but wrong predicted target
    hatali_c = dal_mi &&
               ((atladi_c != bus.islem_ongoru_atladi_i) ||
                (atladi_c && bus.islem_ongoru_atladi_i &&
                 (bus.islem_ongoru_adres_i != hedef_c)));
  end

  // Next-state of the FSM, the registered outputs and the counters
  always_comb begin
    durum_d              = durum_q;
    yurut_guncelle_d     = 1'b0;
    yurut_atladi_d       = yurut_atladi_q;
    yurut_hatali_d       = yurut_hatali_q;
    yurut_ps_d           = yurut_ps_q;
    yurut_adres_d        = yurut_adres_q;
    ps_yonlendir_d       = 1'b0;
    ps_yonlendir_adres_d = ps_yonlendir_adres_q;
    sonuc_gecerli_d      = sonuc_gecerli_q;
    sonuc_deger_d        = sonuc_deger_q;
    dogru_sayac_d        = dogru_sayac_q;
    yanlis_sayac_d       = yanlis_sayac_q;

    // The flush cycle lasts exactly one clock regardless of inputs
    if (durum_q == DURUM_TEMIZLE) begin
      durum_d = DURUM_NORMAL;
    end

    // Drain the result slot; a new accept on the same edge reloads it below
    if (bus.sonuc_hazir_i) begin
      sonuc_gecerli_d = 1'b0;
    end

    if (kabul) begin
      sonuc_gecerli_d = 1'b1;
      sonuc_deger_d   = bag_c;

      if (dal_mi) begin
        yurut_guncelle_d = 1'b1;
        yurut_atladi_d   = atladi_c;
        yurut_hatali_d   = hatali_c;
        yurut_ps_d       = bus.islem_ps_i;
        yurut_adres_d    = hedef_c;

        if (hatali_c) begin
          durum_d              = DURUM_TEMIZLE;
          ps_yonlendir_d       = 1'b1;
          ps_yonlendir_adres_d = atladi_c ? hedef_c : duz_c;
          if (yanlis_sayac_q != SAYAC_MAX) begin
            yanlis_sayac_d = yanlis_sayac_q + 32'd1;
          end
        end else if (dogru_sayac_q != SAYAC_MAX) begin
          dogru_sayac_d = dogru_sayac_q + 32'd1;
        end
      end
    end
  end

  // Register every piece of state; reset clears it all and returns to NORMAL
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge no matter the statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q              <= DURUM_NORMAL;
      yurut_guncelle_q     <= 1'b0;
      yurut_atladi_q       <= 1'b0;
      yurut_hatali_q       <= 1'b0;
      yurut_ps_q           <= '0;
      yurut_adres_q        <= '0;
      ps_yonlendir_q       <= 1'b0;
      ps_yonlendir_adres_q <= '0;
      sonuc_gecerli_q      <= 1'b0;
      sonuc_deger_q        <= '0;
      dogru_sayac_q        <= '0;
      yanlis_sayac_q       <= '0;
    end else begin
      durum_q              <= durum_d;
      yurut_guncelle_q     <= yurut_guncelle_d;
      yurut_atladi_q       <= yurut_atladi_d;
      yurut_hatali_q       <= yurut_hatali_d;
      yurut_ps_q           <= yurut_ps_d;
      yurut_adres_q        <= yurut_adres_d;
      ps_yonlendir_q       <= ps_yonlendir_d;
      ps_yonlendir_adres_q <= ps_yonlendir_adres_d;
      sonuc_gecerli_q      <= sonuc_gecerli_d;
      sonuc_deger_q        <= sonuc_deger_d;
      dogru_sayac_q        <= dogru_sayac_d;
      yanlis_sayac_q       <= yanlis_sayac_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.islem_hazir_o         = islem_hazir;
  assign bus.yurut_guncelle_o      = yurut_guncelle_q;
  assign bus.yurut_atladi_o        = yurut_atladi_q;
  assign bus.yurut_hatali_tahmin_o = yurut_hatali_q;
  assign bus.yurut_ps_o            = yurut_ps_q;
  assign bus.yurut_atlanan_adres_o = yurut_adres_q;
  assign bus.ps_yonlendir_o        = ps_yonlendir_q;
  assign bus.ps_yonlendir_adres_o  = ps_yonlendir_adres_q;
  assign bus.sonuc_gecerli_o       = sonuc_gecerli_q;
  assign bus.sonuc_deger_o         = sonuc_deger_q;
  assign bus.dogru_sayac_o         = dogru_sayac_q;
  assign bus.yanlis_sayac_o        = yanlis_sayac_q;

endmodule
